mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised modulo counter, the next-generation replacement for the fixed 4-bit up-counter used in the formal test suites. Counts over 0..MAX_VALUE in a configurable width, up or down, with enable, synchronous load, wrap or saturate behaviour, a one-cycle boundary event and a sticky reached-max flag. It is intended as a reusable counter primitive and as a formal target: every output is a register or a decode of a register, so properties bind cleanly at posedge clk.

## Interface
- WIDTH, 4: count width in bits; must be ≥ 1.
- MAX_VALUE, 8: terminal value; elaboration error unless 1 ≤ MAX_VALUE ≤ 2**WIDTH−1.
- MODE, MODE_WRAP: boundary behaviour; MODE_WRAP or MODE_SAT (type mode_e).
- clk  input  1  sole clock; all state updates on the posedge.
- reset  input  1  synchronous, active-low; 0 at a posedge puts the block in reset.
- en  input  1  count enable; one step per enabled cycle.
- up  input  1  direction: 1 increments, 0 decrements; sampled only when en=1.
- load  input  1  synchronous load request.
- load_val  input  WIDTH  load value; values above MAX_VALUE are clamped to MAX_VALUE.
- clr_hit  input  1  clears the sticky hit_max flag.
- count  output  WIDTH  current count, registered.
- at_max  output  1  count == MAX_VALUE (decode of count register).
- at_zero  output  1  count == 0 (decode of count register).
- tc  output  1  registered one-cycle boundary-event pulse.
- hit_max  output  1  sticky: count has equalled MAX_VALUE since reset or last clear.

## Operation
- Reset (reset=0 at posedge): count=0, tc=0, hit_max=0; at_zero=1, at_max=0 follow from count. All other inputs ignored.
- Priority per cycle: reset > load > en. en=0 and load=0: count holds, tc=0.
- load=1: count ← min(load_val, MAX_VALUE); tc=0; en and up ignored that cycle.
- en=1, up=1: count < MAX_VALUE → count+1. count == MAX_VALUE → MODE_WRAP: 0, tc=1; MODE_SAT: holds MAX_VALUE, tc=1.
- en=1, up=0: count > 0 → count−1. count == 0 → MODE_WRAP: MAX_VALUE, tc=1; MODE_SAT: holds 0, tc=1.
- tc is high for exactly the cycle following the boundary-event edge; back-to-back boundary events (saturated with en held) give tc high continuously.
- hit_max: set on any edge whose next count == MAX_VALUE (counting, wrap-down or load); clr_hit=1 clears it unless the same edge sets it (set wins).
- Arithmetic: next-value computed in WIDTH+1 bits to avoid overflow when MAX_VALUE == 2**WIDTH−1; result truncated to WIDTH bits after the range check.

## Timing
- Latency: one cycle from input sample to count/tc/hit_max update; at_max/at_zero valid in the same cycle as count.
- No combinational path from any input to any output.
- Reset mid-count: the next edge with reset=0 forces the reset values regardless of load/en; counting resumes on the first edge with reset=1.
- Direction change is effective immediately on the edge it is sampled; no turnaround cycle.

## Structure
- Package mod_counter_pkg: typedef enum mode_e {MODE_WRAP, MODE_SAT}; function next_count (count, up, max, mode) returning next value and the boundary-event flag, shared with the bench reference model.
- Single module; no sub-module. Elaboration checks on WIDTH and MAX_VALUE are assertions in the module.
- Bundled SVA bind file: count ≤ MAX_VALUE always; tc implies previous count at a boundary; hit_max stable unless set/clear conditions hold.

## Test plan
- WIDTH=4, MAX=8, WRAP: release reset, en=1 up=1 for 10 cycles → count 1..8, 0, 1; tc high only in the cycle count shows 0; hit_max rises with count=8 and stays.
- WIDTH=4, MAX=8, SAT: count up to 8, hold en 3 more cycles → count stays 8, tc high for 3 cycles; then up=0 one cycle → count 7, tc=0.
- Down-wrap, WRAP: from reset en=1 up=0 → count 8, tc=1, hit_max=1; next cycle count 7, tc=0.
- Load: load=1 load_val=13 with en=1 → count 8 (clamped), tc=0; load_val=3 → count 3.
- WIDTH=3, MAX=7: count 7 → up wraps to 0 with no width overflow; clr_hit=1 on the same edge count becomes 7 → hit_max remains 1.
- Reset at count=5 with load=1 simultaneous → count 0, tc 0, hit_max 0 on that edge.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types and the next-count step rule for the modulo counter.
package mod_counter_pkg;

    typedef enum logic {MODE_WRAP, MODE_SAT} mode_e;

    localparam int CNT_MAX_W = 32;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] value;
        logic                 tc;
    } step_t;

    // One count step at full width; the extra top bit keeps count+1 from
    // overflowing when max is the all-ones value.
    function automatic step_t next_count(input logic [CNT_MAX_W-1:0] count,
                                         input logic                 up,
                                         input logic [CNT_MAX_W-1:0] max,
                                         input mode_e                mode);
        logic [CNT_MAX_W:0] c;
        step_t r;
        c       = {1'b0, count};
        r.value = count;
        r.tc    = 1'b0;
        if (up) begin
            if (c < {1'b0, max}) begin
                r.value = CNT_MAX_W'(c + 1'b1);
            end else begin
                r.tc    = 1'b1;
                r.value = (mode == MODE_WRAP) ? '0 : max;
            end
        end else begin
            if (count != '0) begin
                r.value = count - 1'b1;
            end else begin
                r.tc    = 1'b1;
                r.value = (mode == MODE_WRAP) ? max : '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_counter_sva.sv
// Protocol properties for mod_counter, attached to every instance via bind.
module mod_counter_sva #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 8
) (
    input logic             clk,
    input logic             reset,
    input logic             en,
    input logic             up,
    input logic             load,
    input logic             clr_hit,
    input logic [WIDTH-1:0] count,
    input logic             tc,
    input logic             hit_max
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);

    a_range: assert property (@(posedge clk) count <= MAXV);

    // A pulse must come from an enabled step taken at a boundary.
    a_tc_cause: assert property (@(posedge clk) disable iff (!reset)
        tc |-> ($past(reset) && $past(en) && !$past(load) &&
                ($past(up) ? ($past(count) == MAXV) : ($past(count) == '0))));

    a_hit_rise: assert property (@(posedge clk) $rose(hit_max) |-> (count == MAXV));

    a_hit_fall: assert property (@(posedge clk)
        $fell(hit_max) |-> (!$past(reset) || $past(clr_hit)));

endmodule

bind mod_counter mod_counter_sva #(.WIDTH(WIDTH), .MAX_VALUE(MAX_VALUE)) u_sva (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .clr_hit(clr_hit),
    .count(count), .tc(tc), .hit_max(hit_max)
);

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate, tc pulse and sticky hit_max.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int    WIDTH     = 4,
    parameter int    MAX_VALUE = 8,
    parameter mode_e MODE      = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_hit,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             tc,
    output logic             hit_max
);

    if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
        $error("mod_counter: WIDTH must be in 1..32");
    end
    if (MAX_VALUE < 1 || longint'(MAX_VALUE) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
        $error("mod_counter: MAX_VALUE must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);

    step_t            step;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] nxt;
    logic             nxt_tc;

    always_comb begin
        step   = next_count(CNT_MAX_W'(count), up, CNT_MAX_W'(MAX_VALUE), MODE);
        ld_val = (load_val > MAXV) ? MAXV : load_val;
        nxt    = count;
        nxt_tc = 1'b0;
        if (load) begin
            nxt = ld_val;
        end else if (en) begin
            nxt    = WIDTH'(step.value);
            nxt_tc = step.tc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= '0;
            tc      <= 1'b0;
            hit_max <= 1'b0;
        end else begin
            count   <= nxt;
            tc      <= nxt_tc;
            // set wins over a same-edge clear
            hit_max <= (nxt == MAXV) | (hit_max & ~clr_hit);
        end
    end

    assign at_max  = (count == MAXV);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three configurations driven in lockstep against an integer model.
module tb_mod_counter;
    import mod_counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset, en, up, load, clr_hit;
    logic [3:0] load_val;

    logic [3:0] cnt0, cnt1;
    logic [2:0] cnt2;
    logic       am0, az0, tc0, hm0;
    logic       am1, az1, tc1, hm1;
    logic       am2, az2, tc2, hm2;

    int checks = 0;
    int errors = 0;

    // model state: 0 = W4/M8 wrap, 1 = W4/M8 sat, 2 = W3/M7 wrap
    int mmax [3] = '{8, 8, 7};
    int mmask[3] = '{15, 15, 7};
    bit msat [3] = '{1'b0, 1'b1, 1'b0};
    int mc   [3];
    bit mtc  [3];
    bit mhit [3];

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MAX_VALUE(8), .MODE(MODE_WRAP)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_hit(clr_hit), .count(cnt0), .at_max(am0), .at_zero(az0), .tc(tc0), .hit_max(hm0));

    mod_counter #(.WIDTH(4), .MAX_VALUE(8), .MODE(MODE_SAT)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_hit(clr_hit), .count(cnt1), .at_max(am1), .at_zero(az1), .tc(tc1), .hit_max(hm1));

    mod_counter #(.WIDTH(3), .MAX_VALUE(7), .MODE(MODE_WRAP)) u_w3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[2:0]),
        .clr_hit(clr_hit), .count(cnt2), .at_max(am2), .at_zero(az2), .tc(tc2), .hit_max(hm2));

    function automatic logic [7:0] dut_vec(input int i);
        case (i)
            0:       return {cnt0, am0, az0, tc0, hm0};
            1:       return {cnt1, am1, az1, tc1, hm1};
            default: return {1'b0, cnt2, am2, az2, tc2, hm2};
        endcase
    endfunction

    function automatic logic [7:0] model_vec(input int i);
        return {4'(mc[i]), mc[i] == mmax[i], mc[i] == 0, mtc[i], mhit[i]};
    endfunction

    // One clock edge; the model applies the counter rules as plain integer arithmetic.
    task automatic tick();
        int lv;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                mc[i] = 0; mtc[i] = 0; mhit[i] = 0;
            end else begin
                mtc[i] = 0;
                lv = int'(load_val) & mmask[i];
                if (load) begin
                    mc[i] = (lv > mmax[i]) ? mmax[i] : lv;
                end else if (en && up) begin
                    if (mc[i] == mmax[i]) begin
                        mtc[i] = 1;
                        mc[i]  = msat[i] ? mmax[i] : 0;
                    end else mc[i] = mc[i] + 1;
                end else if (en) begin
                    if (mc[i] == 0) begin
                        mtc[i] = 1;
                        mc[i]  = msat[i] ? 0 : mmax[i];
                    end else mc[i] = mc[i] - 1;
                end
                mhit[i] = (mc[i] == mmax[i]) || (mhit[i] && !clr_hit);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; up = 1; load = 0; load_val = 0; clr_hit = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0; en = 1; load = 1; load_val = 4'd5;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_vec(i) !== 8'b0000_0100) begin
                errors++;
                $display("FAIL reset inst%0d: got %b want 00000100", i, dut_vec(i));
            end
        end
        reset = 1; idle_inputs();
    endtask

    task automatic test_count_up_wrap();
        int ec;
        do_reset();
        en = 1; up = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            ec = (k + 1) % 9;
            checks++;
            if ({cnt0, tc0, hm0} !== {4'(ec), ec == 0, k >= 7}) begin
                errors++;
                $display("FAIL up_wrap step%0d: got cnt=%0d tc=%b hit=%b want cnt=%0d tc=%b hit=%b",
                         k, cnt0, tc0, hm0, ec, ec == 0, k >= 7);
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
        do_reset();
        en = 1; up = 1;
        for (int k = 0; k < 11; k++) begin
            tick();
            checks++;
            if ({cnt1, tc1} !== {(k < 8) ? 4'(k + 1) : 4'd8, k >= 8}) begin
                errors++;
                $display("FAIL sat step%0d: got cnt=%0d tc=%b", k, cnt1, tc1);
            end
        end
        up = 0;
        tick();
        checks++;
        if ({cnt1, tc1, am1} !== {4'd7, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sat_down: got cnt=%0d tc=%b at_max=%b want 7 0 0", cnt1, tc1, am1);
        end
        idle_inputs();
    endtask

    task automatic test_down_wrap();
        do_reset();
        en = 1; up = 0;
        tick();
        checks++;
        if ({cnt0, tc0, hm0, am0} !== {4'd8, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL down_wrap: got cnt=%0d tc=%b hit=%b want 8 1 1", cnt0, tc0, hm0);
        end
        checks++;
        if ({cnt1, tc1, az1} !== {4'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL down_sat: got cnt=%0d tc=%b want 0 1", cnt1, tc1);
        end
        tick();
        checks++;
        if ({cnt0, tc0} !== {4'd7, 1'b0}) begin
            errors++;
            $display("FAIL down_next: got cnt=%0d tc=%b want 7 0", cnt0, tc0);
        end
        idle_inputs();
    endtask

    task automatic test_load();
        do_reset();
        en = 1; up = 1; load = 1; load_val = 4'd13;
        tick();
        checks++;
        if ({cnt0, tc0, hm0} !== {4'd8, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_clamp: got cnt=%0d tc=%b hit=%b want 8 0 1", cnt0, tc0, hm0);
        end
        load_val = 4'd3;
        tick();
        checks++;
        if ({cnt0, tc0} !== {4'd3, 1'b0}) begin
            errors++;
            $display("FAIL load_3: got cnt=%0d tc=%b want 3 0", cnt0, tc0);
        end
        idle_inputs();
    endtask

    task automatic test_full_width();
        do_reset();
        load = 1; load_val = 4'd6;
        tick();
        load = 0; en = 1; up = 1; clr_hit = 1;
        tick();
        checks++;
        if ({cnt2, am2, hm2} !== {3'd7, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL w3_set_wins: got cnt=%0d at_max=%b hit=%b want 7 1 1", cnt2, am2, hm2);
        end
        clr_hit = 0;
        tick();
        checks++;
        if ({cnt2, tc2, hm2} !== {3'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL w3_wrap: got cnt=%0d tc=%b hit=%b want 0 1 1", cnt2, tc2, hm2);
        end
        en = 0; clr_hit = 1;
        tick();
        checks++;
        if ({cnt2, tc2, hm2} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL w3_clear: got cnt=%0d tc=%b hit=%b want 0 0 0", cnt2, tc2, hm2);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        load = 1; load_val = 4'd8;
        tick();
        load_val = 4'd5;
        tick();
        reset = 0; load = 1; load_val = 4'd7; en = 1;
        tick();
        checks++;
        if ({cnt0, tc0, hm0, az0} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: got cnt=%0d tc=%b hit=%b want 0 0 0", cnt0, tc0, hm0);
        end
        reset = 1;
        idle_inputs();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset    = ($urandom_range(0, 39) != 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 2) != 0);
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
            clr_hit  = ($urandom_range(0, 5) == 0);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec(i) !== model_vec(i)) begin
                    errors++;
                    $display("FAIL random c%0d inst%0d: got %b want %b (cnt,at_max,at_zero,tc,hit)",
                             k, i, dut_vec(i), model_vec(i));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin mc[i] = 0; mtc[i] = 0; mhit[i] = 0; end
        test_reset();
        test_count_up_wrap();
        test_saturate();
        test_down_wrap();
        test_load();
        test_full_width();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
